// File: rtl/fetch.sv
// Instruction fetch unit: sequential word fetch over a req/gnt port with in-order responses.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky HALT state.
module fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_v_x,
    input  logic [31:0] pc_x,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_i,
    output logic        inst_v_i,
    output logic [31:0] inst_i
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_err
`endif
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]     pcq_q [MAX_OUTSTANDING];
    logic            out_v_q, out_v_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            run;
    logic            push;
    logic            pop;
    logic            drop_rsp;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic {StRun, StHalt} state_e;

    state_e state_q, state_d;
    logic   err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            StRun: begin
                if (pc_v_x && (pc_x[1:0] != 2'b00)) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StHalt: state_d = StHalt;
        endcase
    end

    assign run       = (state_q == StRun);
    assign fetch_err = err_q;
`else
    logic unused_pc_x_lsb;
    assign unused_pc_x_lsb = ^pc_x[1:0];
    assign run             = 1'b1;
`endif

    // A response frees a slot in the same cycle, so a full window can still issue.
    assign imem_req  = ~reset & run & ~pc_v_x & ((out_cnt_q < MaxCnt) | imem_rvalid);
    assign imem_addr = fetch_pc_q;
    assign push      = imem_req & imem_gnt;
    assign pop       = imem_rvalid;
    assign drop_rsp  = (drop_cnt_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        out_cnt_d  = out_cnt_q + CntW'(push) - CntW'(pop);
        out_v_d    = imem_rvalid & ~drop_rsp & ~pc_v_x & run;

        if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end

        // Every response still in flight after this cycle belongs to the wrong path.
        if (pc_v_x) begin
            fetch_pc_d = {pc_x[31:2], 2'b00};
            drop_cnt_d = out_cnt_q - CntW'(imem_rvalid);
        end else if (pop && drop_rsp) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end

        if (out_v_d) begin
            pc_d   = pcq_q[rd_ptr_q];
            inst_d = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_v_q    <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_v_q    <= out_v_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcq_q[wr_ptr_q] <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rvalid && (out_cnt_q == '0)));
        end
    end

    assign inst_v_i = out_v_q & ~pc_v_x;
    assign pc_i     = pc_q;
    assign inst_i   = inst_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed table, redirect/wrap/reset sequences, then random traffic
// checked against an epoch-tagged in-flight request model.
module tb_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_v_x = 1'b0;
    logic [31:0] pc_x = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_i;
    logic        inst_v_i;
    logic [31:0] inst_i;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_err;
`endif

    fetch #(
        .RESET_PC       (RESET_PC),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_v_x     (pc_v_x),
        .pc_x       (pc_x),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_i       (pc_i),
        .inst_v_i   (inst_v_i),
        .inst_i     (inst_i)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_err  (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int          ready;
    } req_t;

    typedef struct {
        logic        gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    req_t        mem_q[$];
    int          cyc = 0;
    int unsigned epoch = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        exp_v = 1'b0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_fetch = RESET_PC;
    logic        halted = 1'b0;
    logic        after_reset = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        exp_err = 1'b0;
`endif
    int          n_vec = 0;
    int          n_err = 0;

    logic        cur_rv, cur_req, cur_gnt, cur_redir, cur_rst;
    logic [31:0] cur_tgt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs and check outputs against the model.
    task automatic cycle_begin(input logic gnt, input logic rsp_en, input logic redir,
                               input logic [31:0] tgt, input logic rst);
        cur_rst   = rst;
        cur_gnt   = gnt;
        cur_redir = redir && !rst;
        cur_tgt   = tgt;
        cur_rv    = !rst && rsp_en && (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
        reset       = rst;
        imem_gnt    = gnt;
        pc_v_x      = cur_redir;
        pc_x        = tgt;
        imem_rvalid = cur_rv;
        imem_rdata  = cur_rv ? memf(mem_q[0].addr) : $urandom;
        #2;
        cur_req = 1'b0;
        if (rst) begin
            check("req_in_reset", {31'b0, imem_req}, 32'd0);
        end else begin
            cur_req = !halted && !cur_redir && ((mem_q.size() < MAX_OUT) || cur_rv);
            check("imem_req", {31'b0, imem_req}, {31'b0, cur_req});
            if (cur_req) check("imem_addr", imem_addr, exp_fetch);
            check("inst_v_i", {31'b0, inst_v_i}, {31'b0, exp_v && !cur_redir});
            if (exp_v && !cur_redir) begin
                check("pc_i", pc_i, exp_pc);
                check("inst_i", inst_i, memf(exp_pc));
            end
            if (after_reset) begin
                check("rst_pc_i", pc_i, 32'd0);
                check("rst_inst_i", inst_i, 32'd0);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            check("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
`endif
        end
    endtask

    // Advance the model past the handshakes of this cycle, then clock.
    task automatic cycle_end();
        req_t head;
        if (cur_rst) begin
            mem_q.delete();
            exp_v       = 1'b0;
            exp_fetch   = RESET_PC;
            halted      = 1'b0;
            after_reset = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_err     = 1'b0;
`endif
            epoch++;
        end else begin
            after_reset = 1'b0;
            exp_v       = 1'b0;
            if (cur_rv) begin
                head = mem_q.pop_front();
                if (head.epoch == epoch && !cur_redir && !halted) begin
                    exp_v  = 1'b1;
                    exp_pc = head.addr;
                end
            end
            if (cur_req && cur_gnt) begin
                mem_q.push_back('{exp_fetch, epoch, cyc + $urandom_range(lat_max, lat_min)});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (cur_redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (!halted && (cur_tgt[1:0] != 2'b00)) begin
                    halted  = 1'b1;
                    exp_err = 1'b1;
                end
`endif
                epoch++;
                exp_fetch = {cur_tgt[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic gnt, input logic rsp_en, input logic redir,
                        input logic [31:0] tgt, input logic rst);
        cycle_begin(gnt, rsp_en, redir, tgt, rst);
        cycle_end();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    // Two in flight (0x20, 0x24) with out_v set, then redirect to 0x100.
    task automatic redirect_seq(input logic with_rsp);
        logic found;
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        cycle_begin(1'b1, with_rsp, 1'b1, 32'h100, 1'b0);
        check("redir_kill", {31'b0, inst_v_i}, 32'd0);
        check("redir_noreq", {31'b0, imem_req}, 32'd0);
        cycle_end();
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            if (i == 0) check("redir_next_addr", imem_addr, 32'h100);
            if (inst_v_i) begin
                found = 1'b1;
                check("redir_first_pc", pc_i, 32'h100);
            end
            cycle_end();
        end
        check("redir_first_seen", {31'b0, found}, 32'd1);
    endtask

    vec_t tbl[11];

    initial begin
        logic [31:0] tgt;
        logic        found;

        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[6]  = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
        tbl[7]  = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h00};
        tbl[8]  = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        tbl[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

        @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            cycle_begin(tbl[k].gnt, 1'b1, 1'b0, 32'd0, 1'b0);
            check("tbl_req", {31'b0, imem_req}, {31'b0, tbl[k].exp_req});
            check("tbl_addr", imem_addr, tbl[k].exp_addr);
            check("tbl_inst_v", {31'b0, inst_v_i}, {31'b0, tbl[k].exp_iv});
            if (tbl[k].exp_iv) check("tbl_pc", pc_i, tbl[k].exp_pc);
            cycle_end();
        end

        redirect_seq(1'b0);
        redirect_seq(1'b1);

        // Misaligned redirect.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h102, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 6; k++) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            check("halt_err", {31'b0, fetch_err}, 32'd1);
            check("halt_noreq", {31'b0, imem_req}, 32'd0);
            check("halt_nov", {31'b0, inst_v_i}, 32'd0);
            cycle_end();
        end
`else
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            if (i == 0) check("misalign_addr", imem_addr, 32'h100);
            if (inst_v_i) begin
                found = 1'b1;
                check("misalign_pc", pc_i, 32'h100);
            end
            cycle_end();
        end
        check("misalign_seen", {31'b0, found}, 32'd1);
`endif

        // Address wrap, then reset mid-stream.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        cycle_end();
        cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        cycle_end();
        cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check("wrap_a2", imem_addr, 32'h0000_0000);
        cycle_end();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        cycle_begin(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check("mid_rst_inst_v", {31'b0, inst_v_i}, 32'd0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd1);
        check("mid_rst_addr", imem_addr, RESET_PC);
        cycle_end();

        // Random traffic.
        lat_min = 1;
        lat_max = 4;
        for (int k = 0; k < 4000; k++) begin
            tgt = $urandom;
            if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            step(($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
                 ($urandom_range(19, 0) == 0), tgt, ($urandom_range(199, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch unit feeding the execution stage. It generates sequential word addresses and issues them to the instruction memory over a request/grant port with in-order responses. It presents each returned instruction with its PC on the execution stage's `pc_i`/`inst_v_i`/`inst_i` inputs. It accepts the execution stage's branch redirect (`pc_v_x`/`pc_x`) and discards every in-flight wrong-path fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `MAX_OUTSTANDING`, default 2: maximum in-flight memory requests; legal values 1..4.
- Reset is synchronous and active-high.
- `clk  input  1`: single clock, rising edge.
- `reset  input  1`: synchronous, active-high.
- `pc_v_x  input  1`: redirect valid from the execution stage (taken branch).
- `pc_x  input  32`: redirect target.
- `imem_req  output  1`: fetch request valid.
- `imem_addr  output  32`: fetch word address.
- `imem_gnt  input  1`: request accepted this cycle.
- `imem_rvalid  input  1`: response valid; responses arrive in request order with latency ≥1.
- `imem_rdata  input  32`: response instruction word.
- `pc_i  output  32`: PC of the presented instruction.
- `inst_v_i  output  1`: instruction valid to the execution stage.
- `inst_i  output  32`: instruction word.
- `fetch_err  output  1`: misaligned redirect trap; exists only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `O`: outstanding count, 0..MAX_OUTSTANDING.
  - `D`: drop count, D ≤ O.
  - PC queue: MAX_OUTSTANDING entries, FIFO of issued addresses.
  - Output register: `out_v`, `pc_i`, `inst_i`.
- FSM:
  - RUN: normal fetching.
  - HALT: only with the macro.
  - Reset enters RUN.
- Request: `imem_req = RUN & ~pc_v_x & (O < MAX_OUTSTANDING | imem_rvalid)`. `imem_addr = fetch_pc`.
- On `imem_req & imem_gnt`:
  - push `fetch_pc` into the PC queue;
  - `fetch_pc += 4`, wrapping 32'hFFFF_FFFC → 0;
  - O increments.
- On `imem_rvalid`:
  - pop the PC queue; O decrements.
  - If D > 0: response dropped, D decrements.
  - Else, if `pc_v_x` is low: capture into the output register.
- Same-cycle grant and response: O is unchanged; the queue pushes and pops simultaneously.
- Output register holds for one cycle only; there is no downstream backpressure. `out_v <= imem_rvalid & (D==0) & ~pc_v_x`.
- `inst_v_i = out_v & ~pc_v_x`: a combinational kill of the instruction following a taken branch.
- Redirect (`pc_v_x` high):
  - `fetch_pc <= {pc_x[31:2],2'b00}`;
  - no request this cycle;
  - `D <= O − imem_rvalid`, so all remaining in-flight responses are dropped;
  - PC queue entries remain, so dropped responses still pop.
- Redirect takes priority over any response or grant in the same cycle. A response in that cycle is dropped.
- Back-to-back redirects: each one recomputes D from the current O.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `inst_v_i`=0, `pc_i`=0, `inst_i`=0, `fetch_err`=0;
  - O=D=0; PC queue empty.
- First `imem_req` at `RESET_PC` in the first cycle after `reset` falls.
- Latency from response to instruction: `imem_rvalid` in cycle N → `inst_v_i` in cycle N+1.
- Latency from redirect to first target request: `pc_v_x` in cycle N → `imem_req` at target in cycle N+1.
- Throughput: with memory latency L ≤ MAX_OUTSTANDING, the unit sustains one instruction per cycle.
- Reset mid-operation clears O, D and the queue. The instruction memory is reset by the same `reset`, so no stale responses arrive.
- A response with O==0 is illegal: assertion failure.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - a redirect with `pc_x[1:0]≠0` moves the FSM to HALT and sets `fetch_err`=1, sticky until reset;
  - in HALT: no requests, outstanding responses drained and dropped, `inst_v_i`=0.
- Undefined:
  - `pc_x[1:0]` is ignored (forced to 00);
  - no HALT state; no `fetch_err` port.

## Test plan
- Reset, RESET_PC=0, memory latency 1, always granted → requests 0,4,8,… one per cycle; `inst_v_i` continuous from cycle 2; `pc_i` 0,4,8 with matching `inst_i`.
- `imem_gnt` low for 3 cycles at address 0x10 → `imem_req` held with `imem_addr`=0x10; no duplicate or skipped PCs; `inst_v_i` gap of 3 cycles.
- `pc_v_x`=1, `pc_x`=0x100, with 2 outstanding (0x20, 0x24) and `out_v` set → `inst_v_i` forced 0 that cycle; both responses dropped; next `inst_v_i` carries `pc_i`=0x100.
- Redirect coincident with `imem_rvalid`, O=2 → D=1; that response and the next are dropped; O reaches 0 before any 0x100 response.
- Redirect to 0x102 → with the macro: `fetch_err`=1, no further `imem_req`, `inst_v_i` stays 0. Without: fetch restarts at 0x100.
- `fetch_pc`=0xFFFF_FFFC → next request at 0x0000_0000; reset asserted mid-stream → outputs return to reset values the next cycle.
